pipeline_hazard_ctrl: RTL and testbench

// Sequences the four inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC of the 5-stage RV32I core.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 35 +++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Default register-index width of the RV32I core.
  localparam int REG_W_DEF = 5;

  // One bundle of latch/PC controls, in output order.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_nop;
    logic idex_nop;
    logic exmem_nop;
    logic memwb_nop;
  } ctl_t;

  // Canned control patterns for each pipeline situation.
  localparam ctl_t CTL_RESET  = ctl_t'(9'b0_0000_1111); // everything cleared to NOP
  localparam ctl_t CTL_HOLD   = ctl_t'(9'b0_0000_0000); // full freeze / halted hold
  localparam ctl_t CTL_RUN    = ctl_t'(9'b1_1111_0000); // normal advance
  localparam ctl_t CTL_BRANCH = ctl_t'(9'b1_0011_1100); // redirect, kill IF/ID and ID/EX
  localparam ctl_t CTL_LDUSE  = ctl_t'(9'b0_0011_0100); // hold front, one bubble into EX
  localparam ctl_t CTL_DRAIN  = ctl_t'(9'b0_0111_1000); // fetch blocked, back end drains

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the ID and EX stages.
module pipeline_hazard_ctrl_hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             load_use
);

  logic w_hit1;
  logic w_hit2;

  // x0 is hard-wired zero, so a load into it never creates a dependency.
  always_comb begin
    w_hit1   = id_use1 && (id_rs1 == ex_rd);
    w_hit2   = id_use2 && (id_rs2 == ex_rd);
    load_use = ex_mem_read && (ex_rd != '0) && (w_hit1 || w_hit2);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: state machine, drain counter, latch control decode
// and saturating stall/flush statistics for the 5-stage RV32I core.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W        = REG_W_DEF,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_nop,
  output logic             idex_nop,
  output logic             exmem_nop,
  output logic             memwb_nop,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [DW-1:0]   r_drain;
  logic [DW-1:0]   w_drain_next;
  logic            w_load_use;
  ctl_t            w_ctl;
  logic [1:0]      w_cnt_inc;   // [0] stall, [1] flush
  logic [CNT_W-1:0] r_cnt [2];

  pipeline_hazard_ctrl_hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use1     (id_use1),
    .id_use2     (id_use2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (w_load_use)
  );

  // State and drain counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_drain <= '0;
    end else begin
      r_state <= w_state_next;
      r_drain <= w_drain_next;
    end
  end

  // Next-state and control decode: busy > branch > load-use > state default.
  always_comb begin
    w_state_next = r_state;
    w_drain_next = r_drain;
    w_ctl        = CTL_HOLD;
    w_cnt_inc    = 2'b00;
    if (mem_busy) begin
      // Full freeze: state and drain count stay put, only the stall stat moves.
      w_cnt_inc[0] = (r_state != ST_HALTED);
    end else if (r_state == ST_HALTED) begin
      if (!halt_req) w_state_next = ST_RUN;
    end else begin
      if (ex_br_taken) begin
        w_ctl        = CTL_BRANCH;
        w_cnt_inc[1] = 1'b1;
      end else if (w_load_use) begin
        w_ctl        = CTL_LDUSE;
        w_cnt_inc[0] = 1'b1;
      end else if (r_state == ST_RUN) begin
        w_ctl        = CTL_RUN;
      end else begin
        w_ctl        = CTL_DRAIN;
        w_cnt_inc[0] = 1'b1;
      end
      // Drain progress counts every non-busy cycle, whatever the control pattern.
      if (r_state == ST_RUN) begin
        if (halt_req) begin
          w_state_next = ST_DRAIN;
          w_drain_next = DRAIN_INIT;
        end
      end else if (r_drain == '0) begin
        w_state_next = ST_HALTED;
      end else begin
        w_drain_next = r_drain - 1'b1;
      end
    end
  end

  // Saturating statistics counters.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt[gi] <= '0;
        end else if (w_cnt_inc[gi] && (r_cnt[gi] != {CNT_W{1'b1}})) begin
          r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  // Reset overrides the decode combinationally so outputs react without a clock.
  always_comb begin
    {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
     ifid_nop, idex_nop, exmem_nop, memwb_nop} = rst ? CTL_RESET : w_ctl;
    halted    = !rst && (r_state == ST_HALTED);
    stall_cnt = r_cnt[0];
    flush_cnt = r_cnt[1];
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (CNT_W=4 so saturation is reachable).
module tb_pipeline_hazard_ctrl;

  localparam logic [8:0] C_RESET  = 9'b0_0000_1111;
  localparam logic [8:0] C_HOLD   = 9'b0_0000_0000;
  localparam logic [8:0] C_RUN    = 9'b1_1111_0000;
  localparam logic [8:0] C_BRANCH = 9'b1_0011_1100;
  localparam logic [8:0] C_LDUSE  = 9'b0_0011_0100;
  localparam logic [8:0] C_DRAIN  = 9'b0_0111_1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use1 = 1'b0, id_use2 = 1'b0, ex_mem_read = 1'b0;
  logic       ex_br_taken = 1'b0, mem_busy = 1'b0, halt_req = 1'b0;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_nop, idex_nop, exmem_nop, memwb_nop, halted;
  logic [3:0] stall_cnt, flush_cnt;
  logic [8:0] act_ctl;

  typedef struct {
    string      name;
    logic [8:0] ctl;
    logic       halted;
    logic [3:0] stall;
    logic [3:0] flush;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_W(5), .DRAIN_CYCLES(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .mem_busy(mem_busy), .halt_req(halt_req),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_nop(ifid_nop), .idex_nop(idex_nop),
    .exmem_nop(exmem_nop), .memwb_nop(memwb_nop), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign act_ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_nop, idex_nop, exmem_nop, memwb_nop};

  // Monitor: outputs are valid every cycle; compare against queued expectations on negedge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (act_ctl !== e.ctl || halted !== e.halted ||
          stall_cnt !== e.stall || flush_cnt !== e.flush) begin
        failures++;
        $display("FAIL %s: got ctl=%b halted=%b stall=%0d flush=%0d, want ctl=%b halted=%b stall=%0d flush=%0d",
                 e.name, act_ctl, halted, stall_cnt, flush_cnt,
                 e.ctl, e.halted, e.stall, e.flush);
      end else begin
        $display("txn %s ok ctl=%b halted=%b stall=%0d flush=%0d",
                 e.name, act_ctl, halted, stall_cnt, flush_cnt);
      end
    end
  end

  // Drive one cycle of inputs just after the edge and queue the expected response.
  task automatic step(input string nm, input logic r, input logic bsy, input logic br,
                      input logic hr, input logic ld, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                      input logic u2, input logic [8:0] ctl, input logic hl,
                      input logic [3:0] st, input logic [3:0] fl);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; mem_busy = bsy; ex_br_taken = br; halt_req = hr; ex_mem_read = ld;
    ex_rd = rd; id_rs1 = rs1; id_use1 = u1; id_rs2 = rs2; id_use2 = u2;
    e.name = nm; e.ctl = ctl; e.halted = hl; e.stall = st; e.flush = fl;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic bsy, input logic hr,
                      input logic [8:0] ctl, input logic hl,
                      input logic [3:0] st, input logic [3:0] fl);
    step(nm, 1'b0, bsy, 1'b0, hr, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, ctl, hl, st, fl);
  endtask

  initial begin
    // Reset state
    step("reset", 1'b1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_RESET, 0, 4'd0, 4'd0);
    idle("reset_release", 0, 0, C_RUN, 0, 4'd0, 4'd0);
    // Load-use on rs1: one bubble
    step("lu_rs1", 0, 0, 0, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, C_LDUSE, 0, 4'd0, 4'd0);
    idle("lu_rs1_after", 0, 0, C_RUN, 0, 4'd1, 4'd0);
    // Load to x0 and unused operand: no stall
    step("lu_x0", 0, 0, 0, 0, 1, 5'd0, 5'd0, 1, 5'd0, 0, C_RUN, 0, 4'd1, 4'd0);
    step("lu_nouse", 0, 0, 0, 0, 1, 5'd5, 5'd5, 0, 5'd0, 0, C_RUN, 0, 4'd1, 4'd0);
    // Load-use via rs2
    step("lu_rs2", 0, 0, 0, 0, 1, 5'd7, 5'd3, 1, 5'd7, 1, C_LDUSE, 0, 4'd1, 4'd0);
    idle("lu_rs2_after", 0, 0, C_RUN, 0, 4'd2, 4'd0);
    // Branch beats load-use
    step("br_vs_lu", 0, 0, 1, 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, C_BRANCH, 0, 4'd2, 4'd0);
    idle("br_after", 0, 0, C_RUN, 0, 4'd2, 4'd1);
    // Halt pulse with two busy cycles mid-drain: halted 7 cycles after pulse
    idle("halt_pulse", 0, 1, C_RUN, 0, 4'd2, 4'd1);
    idle("drain1", 0, 0, C_DRAIN, 0, 4'd2, 4'd1);
    idle("drain2", 0, 0, C_DRAIN, 0, 4'd3, 4'd1);
    idle("drain_busy1", 1, 0, C_HOLD, 0, 4'd4, 4'd1);
    idle("drain_busy2", 1, 0, C_HOLD, 0, 4'd5, 4'd1);
    idle("drain3", 0, 0, C_DRAIN, 0, 4'd6, 4'd1);
    idle("drain4", 0, 0, C_DRAIN, 0, 4'd7, 4'd1);
    idle("halted", 0, 0, C_HOLD, 1, 4'd8, 4'd1);
    idle("resume", 0, 0, C_RUN, 0, 4'd8, 4'd1);
    // Busy freeze in RUN, then async reset mid-busy
    step("reset2", 1'b1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_RESET, 0, 4'd0, 4'd0);
    idle("reset2_release", 0, 0, C_RUN, 0, 4'd0, 4'd0);
    idle("busy1", 1, 0, C_HOLD, 0, 4'd0, 4'd0);
    idle("busy2", 1, 0, C_HOLD, 0, 4'd1, 4'd0);
    idle("busy3", 1, 0, C_HOLD, 0, 4'd2, 4'd0);
    idle("busy_cnt3", 1, 0, C_HOLD, 0, 4'd3, 4'd0);
    step("async_rst", 1'b1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_RESET, 0, 4'd0, 4'd0);
    idle("reset3_release", 0, 0, C_RUN, 0, 4'd0, 4'd0);
    // Saturation: 20 load-use stalls on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat_%0d", i), 0, 0, 0, 0, 1, 5'd9, 5'd9, 1, 5'd0, 0,
           C_LDUSE, 0, 4'((i > 15) ? 15 : i), 4'd0);
    end
    idle("sat_hold", 0, 0, C_RUN, 0, 4'd15, 4'd0);
    idle("sat_final", 0, 0, C_RUN, 0, 4'd15, 4'd0);
    // Let the monitor drain the queue, bounded
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
